// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: control-unit requests/redirects, instruction-memory
// read port and the decoded fetch outputs.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             FETCH_REQ;
    logic             REDIRECT_VALID;
    logic [XLEN-1:0]  REDIRECT_PC;
    logic [ILEN-1:0]  MEM_RDATA;
    logic [31:0]      MEM_RADDR;
    logic [XLEN-1:0]  PC;
    logic [ILEN-1:0]  IR;
    logic [6:0]       IR6_0;
    logic [4:0]       IR11_7;
    logic [4:0]       IR19_15;
    logic [4:0]       IR24_20;
    logic             INSTR_VALID;
    logic             BUSY;
    logic             MISALIGNED;
    logic [CNT_W-1:0] FETCH_COUNT;

    modport master (
        output FETCH_REQ, REDIRECT_VALID, REDIRECT_PC, MEM_RDATA,
        input  MEM_RADDR, PC, IR, IR6_0, IR11_7, IR19_15, IR24_20,
               INSTR_VALID, BUSY, MISALIGNED, FETCH_COUNT
    );

    modport slave (
        input  FETCH_REQ, REDIRECT_VALID, REDIRECT_PC, MEM_RDATA,
        output MEM_RADDR, PC, IR, IR6_0, IR11_7, IR19_15, IR24_20,
               INSTR_VALID, BUSY, MISALIGNED, FETCH_COUNT
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns PC, waits MEM_LAT cycles for the
// instruction memory, loads IR, advances PC and exposes decode fields.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     MEM_LAT  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4,
    parameter int unsigned     CNT_W    = 32
) (
    input logic               CLK,
    input logic               RESET,
    instr_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VALID} state_e;

    localparam logic [3:0]      LAST_CNT = 4'(MEM_LAT - 1);
    localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [ILEN-1:0]  ir_q, ir_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             misaligned_q, misaligned_d;
    logic             redirect_ok;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            wait_cnt_q    <= '0;
            fetch_count_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_count_q <= fetch_count_d;
            misaligned_q  <= misaligned_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_count_d = fetch_count_q;
        misaligned_d  = misaligned_q;
        redirect_ok   = bus.REDIRECT_VALID && (bus.REDIRECT_PC[1:0] == 2'b00);

        // A misaligned target only raises the flag; the FSM carries on as if no redirect came.
        if (bus.REDIRECT_VALID && !redirect_ok) begin
            misaligned_d = 1'b1;
        end

        if (redirect_ok) begin
            pc_d       = bus.REDIRECT_PC;
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.FETCH_REQ) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_q == LAST_CNT) begin
                        ir_d          = bus.MEM_RDATA;
                        pc_d          = pc_q + STEP;
                        fetch_count_d = fetch_count_q + 1'b1;
                        wait_cnt_d    = '0;
                        state_d       = ST_VALID;
                    end
                end
                ST_VALID: begin
                    wait_cnt_d = '0;
                    state_d    = bus.FETCH_REQ ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.MEM_RADDR   = pc_q[31:0];
    assign bus.PC          = pc_q;
    assign bus.IR          = ir_q;
    assign bus.IR6_0       = ir_q[6:0];
    assign bus.IR11_7      = ir_q[11:7];
    assign bus.IR19_15     = ir_q[19:15];
    assign bus.IR24_20     = ir_q[24:20];
    assign bus.INSTR_VALID = (state_q == ST_VALID);
    assign bus.BUSY        = (state_q == ST_WAIT);
    assign bus.MISALIGNED  = misaligned_q;
    assign bus.FETCH_COUNT = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: unit A (MEM_LAT=1, 4-bit counter) and unit B (MEM_LAT=3)
// share clock/reset and a small instruction ROM addressed by MEM_RADDR[5:2].
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [31:0] imem [16];

    instr_fetch_unit_if #(.XLEN(64), .ILEN(32), .CNT_W(4))  ifa ();
    instr_fetch_unit_if #(.XLEN(64), .ILEN(32), .CNT_W(32)) ifb ();

    instr_fetch_unit #(.XLEN(64), .ILEN(32), .MEM_LAT(1), .RESET_PC(64'h0),
                       .PC_STEP(4), .CNT_W(4))
        dut_a (.CLK(clk), .RESET(rst), .bus(ifa));

    instr_fetch_unit #(.XLEN(64), .ILEN(32), .MEM_LAT(3), .RESET_PC(64'h0),
                       .PC_STEP(4), .CNT_W(32))
        dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

    assign ifa.MEM_RDATA = imem[ifa.MEM_RADDR[5:2]];
    assign ifb.MEM_RDATA = imem[ifb.MEM_RADDR[5:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0050_0093;
        imem[1]  = 32'h00A0_0113;
        imem[2]  = 32'h0020_81B3;
        imem[15] = 32'h7FF0_0093;

        rst = 1'b1;
        ifa.FETCH_REQ = 1'b0; ifa.REDIRECT_VALID = 1'b0; ifa.REDIRECT_PC = '0;
        ifb.FETCH_REQ = 1'b0; ifb.REDIRECT_VALID = 1'b0; ifb.REDIRECT_PC = '0;
        #12;
        chk("rst_pc",    ifa.PC, 64'h0);
        chk("rst_ir",    ifa.IR, 64'h0);
        chk("rst_busy",  ifa.BUSY, 64'h0);
        chk("rst_valid", ifa.INSTR_VALID, 64'h0);
        chk("rst_mis",   ifa.MISALIGNED, 64'h0);
        chk("rst_cnt",   ifa.FETCH_COUNT, 64'h0);
        rst = 1'b0;
        tick();

        // Single fetch on A, latency 1
        ifa.FETCH_REQ = 1'b1;
        tick();
        chk("a_wait_busy",  ifa.BUSY, 64'h1);
        chk("a_wait_raddr", ifa.MEM_RADDR, 64'h0);
        ifa.FETCH_REQ = 1'b0;
        tick();
        chk("a_valid",   ifa.INSTR_VALID, 64'h1);
        chk("a_ir",      ifa.IR, 64'h0050_0093);
        chk("a_opcode",  ifa.IR6_0, 64'h13);
        chk("a_rd",      ifa.IR11_7, 64'h1);
        chk("a_rs1",     ifa.IR19_15, 64'h0);
        chk("a_rs2",     ifa.IR24_20, 64'h5);
        chk("a_pc",      ifa.PC, 64'h4);
        chk("a_cnt",     ifa.FETCH_COUNT, 64'h1);
        chk("a_vbusy",   ifa.BUSY, 64'h0);
        tick();
        chk("a_idle_valid", ifa.INSTR_VALID, 64'h0);
        chk("a_idle_busy",  ifa.BUSY, 64'h0);
        chk("a_ir_hold",    ifa.IR, 64'h0050_0093);

        // B: three back-to-back fetches, latency 3 -> valid at cycles 3,7,11
        ifb.FETCH_REQ = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            chk("b_b2b_valid", ifb.INSTR_VALID, ((cyc % 4) == 3) ? 64'h1 : 64'h0);
            chk("b_b2b_busy",  ifb.BUSY,        ((cyc % 4) == 3) ? 64'h0 : 64'h1);
            if ((cyc % 4) == 3) begin
                chk("b_b2b_pc", ifb.PC, 64'(cyc + 1));
                chk("b_b2b_ir", ifb.IR, 64'(imem[cyc / 4]));
            end
        end
        ifb.FETCH_REQ = 1'b0;
        tick();
        chk("b_idle_busy", ifb.BUSY, 64'h0);
        chk("b_idle_pc",   ifb.PC, 64'd12);
        chk("b_cnt3",      ifb.FETCH_COUNT, 64'd3);

        // B: aligned redirect in the second WAIT cycle aborts the fetch
        ifb.FETCH_REQ = 1'b1;
        tick();
        ifb.FETCH_REQ = 1'b0;
        tick();
        chk("b_abort_busy_pre", ifb.BUSY, 64'h1);
        ifb.REDIRECT_VALID = 1'b1; ifb.REDIRECT_PC = 64'h100;
        tick();
        ifb.REDIRECT_VALID = 1'b0;
        chk("b_redir_pc",    ifb.PC, 64'h100);
        chk("b_redir_raddr", ifb.MEM_RADDR, 64'h100);
        chk("b_redir_busy",  ifb.BUSY, 64'h0);
        chk("b_redir_ir",    ifb.IR, 64'h0020_81B3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_abort_novalid", ifb.INSTR_VALID, 64'h0);
            chk("b_abort_idle",    ifb.BUSY, 64'h0);
        end
        chk("b_abort_cnt", ifb.FETCH_COUNT, 64'd3);

        // B: misaligned redirect mid-fetch is rejected, fetch completes
        ifb.FETCH_REQ = 1'b1;
        tick();
        ifb.FETCH_REQ = 1'b0;
        ifb.REDIRECT_VALID = 1'b1; ifb.REDIRECT_PC = 64'h102;
        tick();
        ifb.REDIRECT_VALID = 1'b0;
        chk("b_mis_flag", ifb.MISALIGNED, 64'h1);
        chk("b_mis_pc",   ifb.PC, 64'h100);
        chk("b_mis_busy", ifb.BUSY, 64'h1);
        tick();
        tick();
        chk("b_mis_valid", ifb.INSTR_VALID, 64'h1);
        chk("b_mis_pc4",   ifb.PC, 64'h104);
        chk("b_mis_ir",    ifb.IR, 64'h0050_0093);
        chk("b_mis_cnt",   ifb.FETCH_COUNT, 64'd4);
        tick();
        chk("b_mis_sticky", ifb.MISALIGNED, 64'h1);

        // Async reset in the middle of a B fetch
        ifb.FETCH_REQ = 1'b1;
        tick();
        ifb.FETCH_REQ = 1'b0;
        tick();
        chk("b_pre_rst_busy", ifb.BUSY, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_pc",    ifb.PC, 64'h0);
        chk("arst_ir",    ifb.IR, 64'h0);
        chk("arst_busy",  ifb.BUSY, 64'h0);
        chk("arst_valid", ifb.INSTR_VALID, 64'h0);
        chk("arst_cnt",   ifb.FETCH_COUNT, 64'h0);
        chk("arst_mis",   ifb.MISALIGNED, 64'h0);
        chk("arst_a_pc",  ifa.PC, 64'h0);
        #1 rst = 1'b0;
        tick();
        chk("arst_hold_busy", ifb.BUSY, 64'h0);

        // A: PC wrap at the top of the address space
        ifa.REDIRECT_VALID = 1'b1; ifa.REDIRECT_PC = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        ifa.REDIRECT_VALID = 1'b0;
        chk("a_top_pc", ifa.PC, 64'hFFFF_FFFF_FFFF_FFFC);
        ifa.FETCH_REQ = 1'b1;
        tick();
        ifa.FETCH_REQ = 1'b0;
        tick();
        chk("a_wrap_valid", ifa.INSTR_VALID, 64'h1);
        chk("a_wrap_pc",    ifa.PC, 64'h0);
        chk("a_wrap_ir",    ifa.IR, 64'h7FF0_0093);
        chk("a_wrap_cnt",   ifa.FETCH_COUNT, 64'h1);

        // A: 15 more back-to-back fetches; 4-bit counter wraps to 0
        ifa.FETCH_REQ = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk("a_cw_busy", ifa.BUSY, 64'h1);
            tick();
            chk("a_cw_valid", ifa.INSTR_VALID, 64'h1);
            chk("a_cw_cnt",   ifa.FETCH_COUNT, 64'(k % 16));
            chk("a_cw_pc",    ifa.PC, 64'(4 * (k - 1)));
        end

        // A: redirect in VALID beats the same-edge FETCH_REQ
        ifa.REDIRECT_VALID = 1'b1; ifa.REDIRECT_PC = 64'h40;
        tick();
        ifa.REDIRECT_VALID = 1'b0;
        ifa.FETCH_REQ = 1'b0;
        chk("a_vred_pc",    ifa.PC, 64'h40);
        chk("a_vred_busy",  ifa.BUSY, 64'h0);
        chk("a_vred_valid", ifa.INSTR_VALID, 64'h0);
        chk("a_vred_cnt",   ifa.FETCH_COUNT, 64'h0);
        chk("a_vred_mis",   ifa.MISALIGNED, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
